// File: rtl/multiboot_seq_if.sv
// Register-bus and ICAP signal bundle for the warm-reboot controller.
interface multiboot_seq_if;
   logic [7:0]  zxuno_addr;
   logic        regaddr_changed;
   logic        zxuno_regrd;
   logic        zxuno_regwr;
   logic [7:0]  din;
   logic [7:0]  dout;
   logic        oe;
   logic        icap_ce;
   logic        icap_we;
   logic [31:0] icap_data;
   logic        busy;

   modport master (
      output zxuno_addr, regaddr_changed, zxuno_regrd, zxuno_regwr, din,
      input  dout, oe, icap_ce, icap_we, icap_data, busy
   );

   modport slave (
      input  zxuno_addr, regaddr_changed, zxuno_regrd, zxuno_regwr, din,
      output dout, oe, icap_ce, icap_we, icap_data, busy
   );
endinterface

// File: rtl/multiboot_seq.sv
// Warm-reboot controller: holds the flash core address, arms/starts on a
// two-step COREBOOT write, then plays the ICAPE2 IPROG word sequence.
module multiboot_seq #(
   parameter logic [7:0]  ADDR_COREADDR = 8'hFC,
   parameter logic [7:0]  ADDR_COREBOOT = 8'hFD,
   parameter int unsigned ADDR_BYTES    = 3,
   parameter logic [31:0] GOLDEN_CORE   = 32'h00100000,
   parameter logic [7:0]  ARM_KEY       = 8'hA5,
   parameter int unsigned NOP_TAIL      = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   multiboot_seq_if.slave  bus
);

   localparam int unsigned AW    = 8 * ADDR_BYTES;
   localparam int unsigned TOTAL = 7 + NOP_TAIL;

   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

   state_t        state, state_nx;
   logic [8:0]    idx, idx_nx;
   logic          ce_nx, we_nx;
   logic [31:0]   data_nx;
   logic [AW-1:0] addr;
   logic [AW-1:0] addr_sh;
   logic [1:0]    rd_ptr;
   logic          armed;
   logic          regwr_q, regrd_q;
   logic          wr_edge, rd_fall, sel_addr, sel_boot, start, busy_i;

   assign sel_addr = (bus.zxuno_addr == ADDR_COREADDR);
   assign sel_boot = (bus.zxuno_addr == ADDR_COREBOOT);
   assign wr_edge  = bus.zxuno_regwr & ~regwr_q;
   assign rd_fall  = ~bus.zxuno_regrd & regrd_q;
   assign busy_i   = (state != IDLE);
   assign start    = wr_edge && sel_boot && !busy_i && armed
                     && (bus.din != ARM_KEY) && bus.din[0];
   assign bus.busy = busy_i;

   function automatic logic [31:0] icap_word(input logic [8:0] k, input logic [AW-1:0] a);
      case (k)
         9'd0:    return 32'hFFFFFFFF;
         9'd1:    return 32'hAA995566;
         9'd2:    return 32'h20000000;
         9'd3:    return 32'h30020001;
         9'd4:    return {8'h00, a[AW-1 -: 24]};
         9'd5:    return 32'h30008001;
         9'd6:    return 32'h0000000F;
         default: return 32'h20000000;
      endcase
   endfunction

   // Strobe history for rising/falling edge detection.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         regwr_q <= 1'b0;
         regrd_q <= 1'b0;
      end else begin
         regwr_q <= bus.zxuno_regwr;
         regrd_q <= bus.zxuno_regrd;
      end
   end

   // Address shift register, read pointer and arm flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr   <= GOLDEN_CORE[AW-1:0];
         rd_ptr <= '0;
         armed  <= 1'b0;
      end else begin
         if (wr_edge && !busy_i) begin
            if (sel_addr) addr <= {addr[AW-9:0], bus.din};
            // Arm key arms; a start or any other value disarms.
            if (sel_boot) armed <= (bus.din == ARM_KEY);
         end
         if (bus.regaddr_changed && sel_addr)
            rd_ptr <= '0;
         else if (rd_fall && sel_addr)
            rd_ptr <= (rd_ptr == 2'(ADDR_BYTES - 1)) ? '0 : rd_ptr + 2'd1;
      end
   end

   // Read data mux; MSB byte sits at pointer 0.
   always_comb begin
      addr_sh  = addr << {rd_ptr, 3'b000};
      bus.oe   = bus.zxuno_regrd && (sel_addr || sel_boot);
      bus.dout = 8'hFF;
      if (bus.oe)
         bus.dout = sel_addr ? addr_sh[AW-1 -: 8] : {6'b0, armed, busy_i};
   end

   // Sequencer next state and next ICAP word.
   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      ce_nx    = 1'b0;
      we_nx    = 1'b0;
      data_nx  = '0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = SEND;
               idx_nx   = 9'd1;
               data_nx  = icap_word(9'd0, addr);
            end
         end
         SEND: begin
            if (idx == 9'(TOTAL)) begin
               state_nx = DONE;
            end else begin
               idx_nx  = idx + 9'd1;
               ce_nx   = 1'b1;
               we_nx   = 1'b1;
               data_nx = icap_word(idx, addr);
            end
         end
         DONE:    ;
         default: state_nx = IDLE;
      endcase
   end

   // Sequencer state and registered ICAP outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         idx           <= '0;
         bus.icap_ce   <= 1'b0;
         bus.icap_we   <= 1'b0;
         bus.icap_data <= '0;
      end else begin
         state         <= state_nx;
         idx           <= idx_nx;
         bus.icap_ce   <= ce_nx;
         bus.icap_we   <= we_nx;
         bus.icap_data <= data_nx;
      end
   end

endmodule

// File: tb/tb_multiboot_seq.sv
// Scoreboard bench: two instances (3- and 4-byte address) share stimulus;
// a reference model pushes expected reads and ICAP words, a monitor pops.
module tb_multiboot_seq;

   localparam int unsigned NOP = 8;
   localparam int unsigned TOT = 7 + NOP;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   multiboot_seq_if ifa ();
   multiboot_seq_if ifb ();

   multiboot_seq #(.ADDR_BYTES(3), .NOP_TAIL(NOP)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
   multiboot_seq #(.ADDR_BYTES(4), .NOP_TAIL(NOP)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

   int errors = 0;
   int checks = 0;

   logic [31:0] m_addr [2];
   int          m_ptr  [2];
   bit          m_armed[2];
   bit          m_busy [2];
   logic [7:0]  rdq [2][$];
   logic [34:0] icq [2][$];

   logic        s_oe[2], s_busy[2], s_ce[2], s_we[2], oe_prev[2];
   logic [7:0]  s_dout[2];
   logic [31:0] s_data[2];

   function automatic int nbytes(input int d);
      return (d == 0) ? 3 : 4;
   endfunction

   function automatic logic [31:0] amask(input int d);
      return (d == 0) ? 32'h00FFFFFF : 32'hFFFFFFFF;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_addr[d]  = 32'h00100000 & amask(d);
         m_ptr[d]   = 0;
         m_armed[d] = 1'b0;
         m_busy[d]  = 1'b0;
         icq[d].delete();
         rdq[d].delete();
      end
   endtask

   task automatic push_boot(input int d);
      logic [31:0] w[7];
      w[0] = 32'hFFFFFFFF; w[1] = 32'hAA995566; w[2] = 32'h20000000; w[3] = 32'h30020001;
      w[4] = (nbytes(d) == 3) ? m_addr[d] : (m_addr[d] >> 8);
      w[5] = 32'h30008001; w[6] = 32'h0000000F;
      for (int k = 0; k < int'(TOT); k++) begin
         logic [31:0] v;
         v = (k < 7) ? w[k] : 32'h20000000;
         icq[d].push_back({1'b1, (k != 0), (k != 0), v});
      end
      icq[d].push_back({1'b1, 1'b0, 1'b0, 32'h0});
      icq[d].push_back({1'b1, 1'b0, 1'b0, 32'h0});
   endtask

   task automatic model_write(input logic [7:0] a, input logic [7:0] v);
      for (int d = 0; d < 2; d++) begin
         if (!m_busy[d]) begin
            if (a == 8'hFC) begin
               m_addr[d] = ((m_addr[d] << 8) | {24'h0, v}) & amask(d);
            end else if (a == 8'hFD) begin
               if (v == 8'hA5) m_armed[d] = 1'b1;
               else if (m_armed[d] && v[0]) begin
                  m_armed[d] = 1'b0;
                  m_busy[d]  = 1'b1;
                  push_boot(d);
               end else m_armed[d] = 1'b0;
            end
         end
      end
   endtask

   // ---------------- bus drivers ----------------
   task automatic set_bus(input logic [7:0] a, input logic rd, input logic wr,
                          input logic [7:0] v, input logic rc);
      ifa.zxuno_addr = a; ifa.zxuno_regrd = rd; ifa.zxuno_regwr = wr; ifa.din = v; ifa.regaddr_changed = rc;
      ifb.zxuno_addr = a; ifb.zxuno_regrd = rd; ifb.zxuno_regwr = wr; ifb.din = v; ifb.regaddr_changed = rc;
   endtask

   task automatic do_write(input logic [7:0] a, input logic [7:0] v, input int hold);
      set_bus(a, 1'b0, 1'b1, v, 1'b0);
      @(posedge clk); #1;
      model_write(a, v);
      repeat (hold - 1) begin @(posedge clk); #1; end
      set_bus(a, 1'b0, 1'b0, v, 1'b0);
      @(posedge clk); #1;
   endtask

   task automatic do_read(input logic [7:0] a);
      for (int d = 0; d < 2; d++) begin
         if (a == 8'hFC) rdq[d].push_back(8'(m_addr[d] >> (8 * (nbytes(d) - 1 - m_ptr[d]))));
         else            rdq[d].push_back({6'b0, m_armed[d], m_busy[d]});
      end
      set_bus(a, 1'b1, 1'b0, 8'h00, 1'b0);
      repeat (2) begin @(posedge clk); #1; end
      set_bus(a, 1'b0, 1'b0, 8'h00, 1'b0);
      if (a == 8'hFC)
         for (int d = 0; d < 2; d++) m_ptr[d] = (m_ptr[d] + 1) % nbytes(d);
      @(posedge clk); #1;
   endtask

   task automatic do_regchg(input logic [7:0] a);
      set_bus(a, 1'b0, 1'b0, 8'h00, 1'b1);
      @(posedge clk); #1;
      set_bus(a, 1'b0, 1'b0, 8'h00, 1'b0);
      if (a == 8'hFC) for (int d = 0; d < 2; d++) m_ptr[d] = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      s_oe[0] = ifa.oe; s_dout[0] = ifa.dout; s_busy[0] = ifa.busy;
      s_ce[0] = ifa.icap_ce; s_we[0] = ifa.icap_we; s_data[0] = ifa.icap_data;
      s_oe[1] = ifb.oe; s_dout[1] = ifb.dout; s_busy[1] = ifb.busy;
      s_ce[1] = ifb.icap_ce; s_we[1] = ifb.icap_we; s_data[1] = ifb.icap_data;
      for (int d = 0; d < 2; d++) begin
         if (s_oe[d] === 1'b1 && oe_prev[d] !== 1'b1) begin
            if (rdq[d].size() == 0) begin
               checks++; errors++;
               $display("FAIL rd_unexpected dut%0d: got dout %h with no read pending", d, s_dout[d]);
            end else begin
               check($sformatf("read_dut%0d", d), {56'h0, s_dout[d]}, {56'h0, rdq[d].pop_front()});
            end
         end
         oe_prev[d] = s_oe[d];
         if (icq[d].size() > 0) begin
            check($sformatf("icap_dut%0d{busy,ce,we,data}", d),
                  {29'h0, s_busy[d], s_ce[d], s_we[d], s_data[d]}, {29'h0, icq[d].pop_front()});
         end else if (s_busy[d] === 1'b1 && !m_busy[d]) begin
            checks++; errors++;
            $display("FAIL busy_unexpected dut%0d: got busy=1 expected 0", d);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin
      oe_prev[0] = 1'b0; oe_prev[1] = 1'b0;
      model_reset();
      set_bus(8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      rst_n = 1'b1;
      model_reset();

      // reset contents and pointer wrap
      repeat (4) do_read(8'hFC);
      do_read(8'hFD);

      // address write and readback, pointer clear
      do_write(8'hFC, 8'h12, 1); do_write(8'hFC, 8'h34, 1); do_write(8'hFC, 8'h56, 1);
      do_regchg(8'hFC);
      do_read(8'hFC); do_read(8'hFC);
      do_regchg(8'hFC);
      do_read(8'hFC); do_read(8'hFC); do_read(8'hFC);

      // no start without a proper arm
      do_write(8'hFD, 8'h01, 1); do_read(8'hFD);
      do_write(8'hFD, 8'hA5, 1); do_read(8'hFD);
      do_write(8'hFD, 8'h02, 1); do_write(8'hFD, 8'h01, 1); do_read(8'hFD);

      // full boot; writes during busy are ignored
      do_write(8'hFD, 8'hA5, 1); do_write(8'hFD, 8'h01, 1);
      do_write(8'hFC, 8'h99, 1); do_write(8'hFD, 8'hA5, 1);
      do_read(8'hFD); do_read(8'hFC);
      repeat (TOT + 4) begin @(posedge clk); #1; end
      do_reset();

      // held write strobe is a single shift
      do_regchg(8'hFC);
      do_write(8'hFC, 8'h78, 10);
      do_read(8'hFC); do_read(8'hFC); do_read(8'hFC);

      // boot with reset landing while word 5 is on the port
      do_reset();
      do_write(8'hFC, 8'h01, 1); do_write(8'hFC, 8'h23, 1);
      do_write(8'hFC, 8'h45, 1); do_write(8'hFC, 8'h67, 1);
      do_write(8'hFD, 8'hA5, 1); do_write(8'hFD, 8'h01, 1);
      repeat (4) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
      check("reset_midseq_a", {29'h0, ifa.busy, ifa.icap_ce, ifa.icap_we, ifa.icap_data}, 64'h0);
      check("reset_midseq_b", {29'h0, ifb.busy, ifb.icap_ce, ifb.icap_we, ifb.icap_data}, 64'h0);
      @(posedge clk); #1;
      repeat (3) do_read(8'hFC);
      do_read(8'hFD);

      // randomized traffic against the model
      for (int i = 0; i < 80; i++) begin
         int unsigned op;
         logic [7:0] v;
         op = $urandom_range(0, 5);
         v  = 8'($urandom);
         case (op)
            0, 1: do_write(8'hFC, v, int'($urandom_range(1, 4)));
            2:    do_read(8'hFC);
            3:    do_read(8'hFD);
            4: begin
               case ($urandom_range(0, 2))
                  0:       do_write(8'hFD, 8'hA5, int'($urandom_range(1, 3)));
                  1:       do_write(8'hFD, 8'h01, 1);
                  default: do_write(8'hFD, v, 1);
               endcase
            end
            default: do_regchg(($urandom_range(0, 1) == 0) ? 8'hFC : v);
         endcase
         if (m_busy[0]) begin
            repeat (TOT + 4) begin @(posedge clk); #1; end
            do_reset();
         end
      end

      repeat (5) begin @(posedge clk); #1; end
      for (int d = 0; d < 2; d++) begin
         check($sformatf("icap_queue_drained_dut%0d", d), 64'(icq[d].size()), 64'h0);
         check($sformatf("read_queue_drained_dut%0d", d), 64'(rdq[d].size()), 64'h0);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
